// File: rtl/pipe_adder_if.sv
// Handshake and data bundle for pipe_adder.
// The i_SAT field exists only when PIPE_ADDER_SAT_EN is defined.
interface pipe_adder_if #(
  parameter int p_WIDTH = 32
);
  logic               i_VALID;
  logic               o_READY;
  logic [p_WIDTH-1:0] i_DIN0;
  logic [p_WIDTH-1:0] i_DIN1;
  logic               i_CIN;
  logic               i_SUB;
`ifdef PIPE_ADDER_SAT_EN
  logic               i_SAT;
`endif
  logic               o_VALID;
  logic               i_READY;
  logic [p_WIDTH-1:0] o_DOUT;
  logic               o_CARRY;
  logic               o_OVERFLOW;
  logic               o_ZERO;

  // slave is the adder itself; master is whoever issues operations and takes results
  modport slave (
`ifdef PIPE_ADDER_SAT_EN
    input  i_SAT,
`endif
    input  i_VALID, i_DIN0, i_DIN1, i_CIN, i_SUB, i_READY,
    output o_READY, o_VALID, o_DOUT, o_CARRY, o_OVERFLOW, o_ZERO
  );

  modport master (
`ifdef PIPE_ADDER_SAT_EN
    output i_SAT,
`endif
    output i_VALID, i_DIN0, i_DIN1, i_CIN, i_SUB, i_READY,
    input  o_READY, o_VALID, o_DOUT, o_CARRY, o_OVERFLOW, o_ZERO
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with chunked carry chain, valid/ready on both sides, carry/overflow/zero flags.
// Optional saturation is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder #(
  parameter int p_WIDTH = 32,
  parameter int p_CHUNK = 8
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  pipe_adder_if.slave bus
);
  localparam int N = p_WIDTH / p_CHUNK;

  logic               en;
  logic [p_WIDTH-1:0] raw_sum;
  logic               raw_carry;
  logic               raw_overflow;
  logic               last_valid;
`ifdef PIPE_ADDER_SAT_EN
  logic               last_sat;
  logic               last_sub;
`endif
  logic [p_WIDTH-1:0] dout_next;
  logic               zero_next;

  logic               valid_reg;
  logic [p_WIDTH-1:0] dout_reg;
  logic               carry_reg;
  logic               overflow_reg;
  logic               zero_reg;

  // One enable freezes the whole pipe, so bubbles keep their slots and order is preserved.
  assign en          = !valid_reg || bus.i_READY;
  assign bus.o_READY = en;

  // Stage gi sees the not-yet-added operand chunks (gi..N-1) right-aligned in a_up/b_up,
  // so its own chunk is always the low p_CHUNK bits; finished chunks accumulate in res.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      localparam int UP = p_WIDTH - gi * p_CHUNK;

      logic [UP-1:0]              a_up;
      logic [UP-1:0]              b_up;
      logic                       carry_up;
      logic                       valid_up;
      logic [p_CHUNK:0]           sum;
      logic [(gi+1)*p_CHUNK-1:0]  res;
`ifdef PIPE_ADDER_SAT_EN
      logic                       sat_up;
      logic                       sub_up;
`endif

      if (gi == 0) begin : g_first
        assign a_up     = bus.i_DIN0;
        assign b_up     = bus.i_SUB ? ~bus.i_DIN1 : bus.i_DIN1;
        assign carry_up = bus.i_SUB | bus.i_CIN;
        assign valid_up = bus.i_VALID;
        assign res      = sum[p_CHUNK-1:0];
`ifdef PIPE_ADDER_SAT_EN
        assign sat_up   = bus.i_SAT;
        assign sub_up   = bus.i_SUB;
`endif
      end else begin : g_next
        assign a_up     = g_stage[gi-1].g_reg.a_reg;
        assign b_up     = g_stage[gi-1].g_reg.b_reg;
        assign carry_up = g_stage[gi-1].g_reg.stage_carry_reg;
        assign valid_up = g_stage[gi-1].g_reg.stage_valid_reg;
        assign res      = {sum[p_CHUNK-1:0], g_stage[gi-1].g_reg.res_reg};
`ifdef PIPE_ADDER_SAT_EN
        assign sat_up   = g_stage[gi-1].g_reg.stage_sat_reg;
        assign sub_up   = g_stage[gi-1].g_reg.stage_sub_reg;
`endif
      end

      assign sum = {1'b0, a_up[p_CHUNK-1:0]} + {1'b0, b_up[p_CHUNK-1:0]}
                 + {{p_CHUNK{1'b0}}, carry_up};

      if (gi < N - 1) begin : g_reg
        logic [UP-p_CHUNK-1:0]     a_reg;
        logic [UP-p_CHUNK-1:0]     b_reg;
        logic [(gi+1)*p_CHUNK-1:0] res_reg;
        logic                      stage_carry_reg;
        logic                      stage_valid_reg;
`ifdef PIPE_ADDER_SAT_EN
        logic                      stage_sat_reg;
        logic                      stage_sub_reg;
`endif

        always_ff @(posedge i_CLK or negedge i_RST_N) begin
          if (!i_RST_N) begin
            a_reg           <= '0;
            b_reg           <= '0;
            res_reg         <= '0;
            stage_carry_reg <= 1'b0;
            stage_valid_reg <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
            stage_sat_reg   <= 1'b0;
            stage_sub_reg   <= 1'b0;
`endif
          end else if (en) begin
            a_reg           <= a_up[UP-1:p_CHUNK];
            b_reg           <= b_up[UP-1:p_CHUNK];
            res_reg         <= res;
            stage_carry_reg <= sum[p_CHUNK];
            stage_valid_reg <= valid_up;
`ifdef PIPE_ADDER_SAT_EN
            stage_sat_reg   <= sat_up;
            stage_sub_reg   <= sub_up;
`endif
          end
        end
      end else begin : g_last
        assign raw_sum      = res;
        assign raw_carry    = sum[p_CHUNK];
        // Same-sign operands giving an opposite-sign result == carry-in(MSB) ^ carry-out(MSB).
        assign raw_overflow = (a_up[p_CHUNK-1] == b_up[p_CHUNK-1]) &&
                              (sum[p_CHUNK-1] != a_up[p_CHUNK-1]);
        assign last_valid   = valid_up;
`ifdef PIPE_ADDER_SAT_EN
        assign last_sat     = sat_up;
        assign last_sub     = sub_up;
`endif
      end
    end
  endgenerate

  always_comb begin
    dout_next = raw_sum;
`ifdef PIPE_ADDER_SAT_EN
    if (last_sat && !last_sub && raw_carry) begin
      dout_next = '1;
    end else if (last_sat && last_sub && !raw_carry) begin
      dout_next = '0;
    end
`endif
  end

  assign zero_next = (dout_next == '0);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      valid_reg    <= 1'b0;
      dout_reg     <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (en) begin
      valid_reg    <= last_valid;
      dout_reg     <= dout_next;
      carry_reg    <= raw_carry;
      overflow_reg <= raw_overflow;
      zero_reg     <= zero_next;
    end
  end

  assign bus.o_VALID    = valid_reg;
  assign bus.o_DOUT     = dout_reg;
  assign bus.o_CARRY    = carry_reg;
  assign bus.o_OVERFLOW = overflow_reg;
  assign bus.o_ZERO     = zero_reg;
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (32-bit, 8-bit chunks) against an arithmetic reference model.
// Saturation scenarios run only when PIPE_ADDER_SAT_EN is defined.
module tb_pipe_adder;
  localparam int W     = 32;
  localparam int CHUNK = 8;
  localparam int LAT   = W / CHUNK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic [W-1:0] r;
    logic         c;
    logic         ov;
    logic         z;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  op_t  exp_q[$];

  pipe_adder_if #(.p_WIDTH(W)) bus ();

  pipe_adder #(.p_WIDTH(W), .p_CHUNK(CHUNK)) dut (
    .i_CLK  (clk),
    .i_RST_N(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic op_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub, input logic sat);
    op_t    o;
    longint ua, ub, sa, sb, full, sfull;
    ua = a;
    ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      full  = ua - ub;
      sfull = sa - sb;
      o.c   = (ua >= ub);
    end else begin
      full  = ua + ub + longint'(cin);
      sfull = sa + sb + longint'(cin);
      o.c   = (full > 64'sd4294967295);
    end
    o.r  = full[W-1:0];
    o.ov = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    if (sat && !sub && o.c) o.r = '1;
    if (sat && sub && !o.c) o.r = '0;
    o.z   = (o.r == '0);
    o.a   = a;
    o.b   = b;
    o.cin = cin;
    o.sub = sub;
    o.sat = sat;
    return o;
  endfunction

  task automatic drive_idle();
    bus.i_VALID = 1'b0;
    bus.i_DIN0  = '0;
    bus.i_DIN1  = '0;
    bus.i_CIN   = 1'b0;
    bus.i_SUB   = 1'b0;
    bus.i_READY = 1'b1;
`ifdef PIPE_ADDER_SAT_EN
    bus.i_SAT   = 1'b0;
`endif
  endtask

  // Issues one op at a negedge with i_READY=1 and waits (bounded) for its result.
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic sat,
                            output logic [W-1:0] r, output logic c, output logic ov,
                            output logic z, output int lat);
    bus.i_DIN0  = a;
    bus.i_DIN1  = b;
    bus.i_CIN   = cin;
    bus.i_SUB   = sub;
`ifdef PIPE_ADDER_SAT_EN
    bus.i_SAT   = sat;
`endif
    bus.i_READY = 1'b1;
    bus.i_VALID = 1'b1;
    @(negedge clk);
    bus.i_VALID = 1'b0;
    lat = 1;
    while (bus.o_VALID !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r  = bus.o_DOUT;
    c  = bus.o_CARRY;
    ov = bus.o_OVERFLOW;
    z  = bus.o_ZERO;
    $display("[TB] op a=%h b=%h cin=%b sub=%b sat=%b -> dout=%h c=%b ov=%b z=%b lat=%0d",
             a, b, cin, sub, sat, r, c, ov, z, lat);
  endtask

  task automatic test_reset();
    drive_idle();
    bus.i_READY = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.o_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.o_VALID); end
    tests_run++; if (bus.o_DOUT !== '0) begin tests_failed++; $display("FAIL reset_dout: got %h want 0", bus.o_DOUT); end
    tests_run++; if (bus.o_CARRY !== 1'b0) begin tests_failed++; $display("FAIL reset_carry: got %b want 0", bus.o_CARRY); end
    tests_run++; if (bus.o_OVERFLOW !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", bus.o_OVERFLOW); end
    tests_run++; if (bus.o_ZERO !== 1'b0) begin tests_failed++; $display("FAIL reset_zero: got %b want 0", bus.o_ZERO); end
    tests_run++; if (bus.o_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.o_READY); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.o_VALID !== 1'b0) begin tests_failed++; $display("FAIL idle_valid: got %b want 0", bus.o_VALID); end
    tests_run++; if (bus.o_READY !== 1'b1) begin tests_failed++; $display("FAIL idle_ready: got %b want 1", bus.o_READY); end
    $display("[TB] reset checks done");
    bus.i_READY = 1'b1;
  endtask

  task automatic test_add();
    logic [W-1:0] r;
    logic c, ov, z;
    int lat;
    run_single(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, r, c, ov, z, lat);
    tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL add_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (r !== 32'h00000100) begin tests_failed++; $display("FAIL add_ff_dout: got %h want 00000100", r); end
    tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL add_ff_carry: got %b want 0", c); end
    run_single(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'h00000000) begin tests_failed++; $display("FAIL add_wrap_dout: got %h want 00000000", r); end
    tests_run++; if (c !== 1'b1) begin tests_failed++; $display("FAIL add_wrap_carry: got %b want 1", c); end
    tests_run++; if (z !== 1'b1) begin tests_failed++; $display("FAIL add_wrap_zero: got %b want 1", z); end
    tests_run++; if (ov !== 1'b0) begin tests_failed++; $display("FAIL add_wrap_overflow: got %b want 0", ov); end
    run_single(32'h12345678, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'h12355678) begin tests_failed++; $display("FAIL add_cin_dout: got %h want 12355678", r); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] r;
    logic c, ov, z;
    int lat;
    run_single(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'h80000000) begin tests_failed++; $display("FAIL ovf_pos_dout: got %h want 80000000", r); end
    tests_run++; if (ov !== 1'b1) begin tests_failed++; $display("FAIL ovf_pos_overflow: got %b want 1", ov); end
    tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL ovf_pos_carry: got %b want 0", c); end
    run_single(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'h00000000) begin tests_failed++; $display("FAIL ovf_neg_dout: got %h want 00000000", r); end
    tests_run++; if (ov !== 1'b1) begin tests_failed++; $display("FAIL ovf_neg_overflow: got %b want 1", ov); end
    tests_run++; if (c !== 1'b1) begin tests_failed++; $display("FAIL ovf_neg_carry: got %b want 1", c); end
    tests_run++; if (z !== 1'b1) begin tests_failed++; $display("FAIL ovf_neg_zero: got %b want 1", z); end
  endtask

  task automatic test_sub();
    logic [W-1:0] r;
    logic c, ov, z;
    int lat;
    run_single(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL sub_5_7_dout: got %h want fffffffe", r); end
    tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL sub_5_7_carry: got %b want 0", c); end
    // carry-in must be ignored in subtract mode
    run_single(32'd7, 32'd5, 1'b1, 1'b1, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'h00000002) begin tests_failed++; $display("FAIL sub_7_5_dout: got %h want 00000002", r); end
    tests_run++; if (c !== 1'b1) begin tests_failed++; $display("FAIL sub_7_5_carry: got %b want 1", c); end
  endtask

`ifdef PIPE_ADDER_SAT_EN
  task automatic test_sat();
    logic [W-1:0] r;
    logic c, ov, z;
    int lat;
    run_single(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, r, c, ov, z, lat);
    tests_run++; if (r !== 32'h00000000) begin tests_failed++; $display("FAIL sat_sub_dout: got %h want 00000000", r); end
    tests_run++; if (c !== 1'b0) begin tests_failed++; $display("FAIL sat_sub_carry: got %b want 0", c); end
    tests_run++; if (z !== 1'b1) begin tests_failed++; $display("FAIL sat_sub_zero: got %b want 1", z); end
    run_single(32'hFFFFFFF0, 32'h00000020, 1'b0, 1'b0, 1'b1, r, c, ov, z, lat);
    tests_run++; if (r !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL sat_add_dout: got %h want ffffffff", r); end
    tests_run++; if (c !== 1'b1) begin tests_failed++; $display("FAIL sat_add_carry: got %b want 1", c); end
  endtask
`endif

  task automatic test_back_to_back();
    op_t          cur;
    op_t          exp;
    logic         need_new;
    logic         stall_prev;
    logic [W-1:0] snap_dout;
    logic         snap_c, snap_ov, snap_z;
    logic [W-1:0] pick_b;
    logic         pick_sat;
    int           issued, received, cycles;

    drive_idle();
    @(negedge clk);
    exp_q.delete();
    need_new   = 1'b1;
    stall_prev = 1'b0;
    snap_dout  = '0;
    snap_c     = 1'b0;
    snap_ov    = 1'b0;
    snap_z     = 1'b0;
    issued     = 0;
    received   = 0;
    cycles     = 0;
    cur        = model('0, '0, 1'b0, 1'b0, 1'b0);

    while (received < 64 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (stall_prev) begin
        tests_run++;
        if (bus.o_VALID !== 1'b1 || bus.o_DOUT !== snap_dout || bus.o_CARRY !== snap_c ||
            bus.o_OVERFLOW !== snap_ov || bus.o_ZERO !== snap_z) begin
          tests_failed++;
          $display("FAIL stall_hold: got v=%b %h c=%b ov=%b z=%b want v=1 %h c=%b ov=%b z=%b",
                   bus.o_VALID, bus.o_DOUT, bus.o_CARRY, bus.o_OVERFLOW, bus.o_ZERO,
                   snap_dout, snap_c, snap_ov, snap_z);
        end
      end
      if (need_new && issued < 64) begin
        case ($urandom_range(0, 5))
          0:       pick_b = 32'hFFFFFFFF;
          1:       pick_b = 32'h80000000;
          2:       pick_b = 32'h00000001;
          default: pick_b = $urandom;
        endcase
        pick_sat = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
        pick_sat = 1'($urandom_range(0, 1));
`endif
        cur = model($urandom, pick_b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_sat);
        bus.i_DIN0  = cur.a;
        bus.i_DIN1  = cur.b;
        bus.i_CIN   = cur.cin;
        bus.i_SUB   = cur.sub;
`ifdef PIPE_ADDER_SAT_EN
        bus.i_SAT   = cur.sat;
`endif
        bus.i_VALID = 1'b1;
        need_new    = 1'b0;
      end else if (need_new) begin
        bus.i_VALID = 1'b0;
      end
      bus.i_READY = ($urandom_range(0, 3) != 0);
      #1;
      tests_run++;
      if (bus.o_READY !== (!bus.o_VALID || bus.i_READY)) begin
        tests_failed++;
        $display("FAIL ready_rule: got %b want %b (o_VALID=%b i_READY=%b)",
                 bus.o_READY, !bus.o_VALID || bus.i_READY, bus.o_VALID, bus.i_READY);
      end
      if (bus.o_VALID === 1'b1 && bus.i_READY === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_extra: got result %h want none pending", bus.o_DOUT);
        end else begin
          exp = exp_q.pop_front();
          $display("[TB] stream #%0d a=%h b=%h cin=%b sub=%b sat=%b -> dout=%h c=%b ov=%b z=%b",
                   received, exp.a, exp.b, exp.cin, exp.sub, exp.sat,
                   bus.o_DOUT, bus.o_CARRY, bus.o_OVERFLOW, bus.o_ZERO);
          if (bus.o_DOUT !== exp.r || bus.o_CARRY !== exp.c ||
              bus.o_OVERFLOW !== exp.ov || bus.o_ZERO !== exp.z) begin
            tests_failed++;
            $display("FAIL stream_result #%0d: got %h c=%b ov=%b z=%b want %h c=%b ov=%b z=%b",
                     received, bus.o_DOUT, bus.o_CARRY, bus.o_OVERFLOW, bus.o_ZERO,
                     exp.r, exp.c, exp.ov, exp.z);
          end
        end
        received++;
      end
      if (bus.i_VALID === 1'b1 && bus.o_READY === 1'b1) begin
        exp_q.push_back(cur);
        issued++;
        need_new = 1'b1;
      end
      stall_prev = (bus.o_VALID === 1'b1) && (bus.i_READY === 1'b0);
      snap_dout  = bus.o_DOUT;
      snap_c     = bus.o_CARRY;
      snap_ov    = bus.o_OVERFLOW;
      snap_z     = bus.o_ZERO;
    end

    tests_run++;
    if (received != 64) begin
      tests_failed++;
      $display("FAIL stream_timeout: got %0d results want 64", received);
    end
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || bus.o_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_drain: got pending=%0d o_VALID=%b want 0 and 0", exp_q.size(), bus.o_VALID);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r;
    logic c, ov, z;
    int lat;
    drive_idle();
    bus.i_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_DIN0  = $urandom;
      bus.i_DIN1  = $urandom;
      bus.i_VALID = 1'b1;
      @(negedge clk);
    end
    bus.i_VALID = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.o_VALID !== 1'b1) begin tests_failed++; $display("FAIL midrst_before: got o_VALID=%b want 1", bus.o_VALID); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.o_VALID !== 1'b0) begin tests_failed++; $display("FAIL midrst_async_valid: got %b want 0", bus.o_VALID); end
    tests_run++; if (bus.o_DOUT !== '0) begin tests_failed++; $display("FAIL midrst_async_dout: got %h want 0", bus.o_DOUT); end
    tests_run++; if (bus.o_READY !== 1'b1) begin tests_failed++; $display("FAIL midrst_async_ready: got %b want 1", bus.o_READY); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_VALID !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrst_stale: got o_VALID=%b dout=%h want 0 at cycle %0d", bus.o_VALID, bus.o_DOUT, i);
      end
    end
    run_single(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, r, c, ov, z, lat);
    tests_run++; if (r !== 32'd3) begin tests_failed++; $display("FAIL midrst_next_dout: got %h want 00000003", r); end
    tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, LAT); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_add();
    test_overflow();
    test_sub();
`ifdef PIPE_ADDER_SAT_EN
    test_sat();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
